run_feeder: RTL and testbench

Producer-side counterpart to the 2-way tuple merger. It accepts a stream of sorted 32-bit keys organised into runs and packs them into 64-bit two-key tuples. It terminates each run with an all-zero tuple and presents the result through a first-word-fall-through FIFO read port (tuple, empty, read). That port is exactly what one merger input expects to read from. One `run_feeder` instance drives each merger input.

---
 rtl/run_feeder_pkg.sv | 24 ++
 rtl/run_feeder_if.sv | 45 ++++
 rtl/run_feeder_fifo.sv | 58 +++++
 rtl/run_feeder.sv | 145 ++++++++++++++
 tb/tb_run_feeder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/run_feeder_pkg.sv
// run_feeder_pkg: shared key width, terminator value, feeder state encoding and tuple layout.
`default_nettype none

package run_feeder_pkg;

    localparam int KEY_W = 32;

    typedef struct packed {
        logic [KEY_W-1:0] hi;
        logic [KEY_W-1:0] lo;
    } tuple_t;

    localparam logic [KEY_W-1:0] TERM_KEY   = '0;
    localparam tuple_t           TERM_TUPLE = '0;

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_HIGH = 2'd1,
        ST_TERM = 2'd2
    } feed_state_e;

endpackage

`default_nettype wire

// File: rtl/run_feeder_if.sv
// run_feeder_if: key input stream and FWFT tuple read port of one run_feeder.
// The RUN_FEEDER_ORDER_CHECK_EN macro adds the err_order flag.
`default_nettype none

interface run_feeder_if
    import run_feeder_pkg::*;
#(
    parameter int W     = KEY_W,
    parameter int CNT_W = 16
);
    logic [W-1:0]     elem;
    logic             elem_valid;
    logic             elem_last;
    logic             elem_ready;
    logic [2*W-1:0]   tuple;
    logic             empty;
    logic             read;
    logic [CNT_W-1:0] run_count;
    logic             err_zero;
    logic             underrun;
`ifdef RUN_FEEDER_ORDER_CHECK_EN
    logic             err_order;

    modport master (
        output elem, elem_valid, elem_last, read,
        input  elem_ready, tuple, empty, run_count, err_zero, underrun, err_order
    );
    modport slave (
        input  elem, elem_valid, elem_last, read,
        output elem_ready, tuple, empty, run_count, err_zero, underrun, err_order
    );
`else
    modport master (
        output elem, elem_valid, elem_last, read,
        input  elem_ready, tuple, empty, run_count, err_zero, underrun
    );
    modport slave (
        input  elem, elem_valid, elem_last, read,
        output elem_ready, tuple, empty, run_count, err_zero, underrun
    );
`endif

endinterface

`default_nettype wire

// File: rtl/run_feeder_fifo.sv
// feeder_fifo: first-word-fall-through circular buffer with wrap-bit pointers
// and a sticky underrun flag for reads issued while empty.
`default_nettype none

module feeder_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic                  underrun
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            underrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (pop && empty) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/run_feeder.sv
// run_feeder: packs sorted key runs into two-key tuples, closes each run with a zero tuple.
// Optional RUN_FEEDER_ORDER_CHECK_EN adds a sticky in-run ordering error flag.
`default_nettype none

module run_feeder
    import run_feeder_pkg::*;
#(
    parameter int W     = KEY_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    run_feeder_if.slave bus
);
    localparam logic [1:0] S_LOW  = ST_LOW;
    localparam logic [1:0] S_HIGH = ST_HIGH;
    localparam logic [1:0] S_TERM = ST_TERM;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [W-1:0]     lo_q;
    logic             lo_load;
    logic             push;
    logic [2*W-1:0]   push_data;
    logic             full;
    logic             accept;
    logic             key_zero;
    logic [CNT_W-1:0] run_count_q;
    logic             err_zero_q;

    assign bus.elem_ready = (state != S_TERM) && !full;
    assign accept         = bus.elem_valid && bus.elem_ready;
    assign key_zero       = (bus.elem == '0);
    assign bus.run_count  = run_count_q;
    assign bus.err_zero   = err_zero_q;

    // Zero keys are dropped; only their last flag influences the FSM.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = '0;
        lo_load   = 1'b0;
        case (state)
            S_LOW: begin
                if (accept) begin
                    if (!key_zero) begin
                        if (bus.elem_last) begin
                            push      = 1'b1;
                            push_data = {{W{1'b0}}, bus.elem};
                            state_nxt = S_TERM;
                        end else begin
                            lo_load   = 1'b1;
                            state_nxt = S_HIGH;
                        end
                    end else if (bus.elem_last) begin
                        state_nxt = S_TERM;
                    end
                end
            end
            S_HIGH: begin
                if (accept) begin
                    if (!key_zero) begin
                        push      = 1'b1;
                        push_data = {bus.elem, lo_q};
                        state_nxt = bus.elem_last ? S_TERM : S_LOW;
                    end else if (bus.elem_last) begin
                        push      = 1'b1;
                        push_data = {{W{1'b0}}, lo_q};
                        state_nxt = S_TERM;
                    end
                end
            end
            S_TERM: begin
                if (!full) begin
                    push      = 1'b1;
                    state_nxt = S_LOW;
                end
            end
            default: state_nxt = S_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOW;
            lo_q        <= '0;
            run_count_q <= '0;
            err_zero_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (lo_load) begin
                lo_q <= bus.elem;
            end
            if ((state == S_TERM) && !full) begin
                run_count_q <= run_count_q + CNT_W'(1);
            end
            if (accept && key_zero) begin
                err_zero_q <= 1'b1;
            end
        end
    end

`ifdef RUN_FEEDER_ORDER_CHECK_EN
    logic [W-1:0] prev_q;
    logic         err_order_q;

    assign bus.err_order = err_order_q;

    // prev_q of zero means "no key yet in this run"; real keys are never zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            err_order_q <= 1'b0;
        end else if (accept) begin
            if (!key_zero && (bus.elem < prev_q)) begin
                err_order_q <= 1'b1;
            end
            if (bus.elem_last) begin
                prev_q <= '0;
            end else if (!key_zero) begin
                prev_q <= bus.elem;
            end
        end
    end
`endif

    feeder_fifo #(
        .WIDTH (2*W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.read),
        .pop_data  (bus.tuple),
        .full      (full),
        .empty     (bus.empty),
        .underrun  (bus.underrun)
    );

endmodule

`default_nettype wire

// File: tb/tb_run_feeder.sv
// tb_run_feeder: scoreboard bench; a key-level model queues expected tuples, a negedge monitor compares pops.
// Covers RUN_FEEDER_ORDER_CHECK_EN when that macro is defined.
`default_nettype none

module tb_run_feeder;
    import run_feeder_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    run_feeder_if #(.W(KEY_W), .CNT_W(16)) bus ();

    run_feeder #(.W(KEY_W), .DEPTH(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb [$];
    logic [31:0] m_lo    = '0;
    bit          m_have  = 1'b0;
    logic [31:0] m_prev  = '0;
    bit          m_order = 1'b0;
    bit          m_zero  = 1'b0;
    int          m_runs  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [31:0] hi, input logic [31:0] lo);
        tuple_t t;
        t.hi = hi;
        t.lo = lo;
        return t;
    endfunction

    // Monitor pops first, then the model queues what the accepted key will produce.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_have  = 1'b0;
            m_prev  = '0;
            m_order = 1'b0;
            m_zero  = 1'b0;
            m_runs  = 0;
        end else begin
            if (bus.read && !bus.empty) begin
                if (sb.size() == 0) check_val("extra_tuple", bus.tuple, TERM_TUPLE ^ 64'hFFFF_FFFF_FFFF_FFFF);
                else                check_val("tuple", bus.tuple, sb.pop_front());
            end
            if (bus.elem_valid && bus.elem_ready) begin
                if (bus.elem == TERM_KEY) begin
                    m_zero = 1'b1;
                end else begin
                    if (bus.elem < m_prev) m_order = 1'b1;
                    m_prev = bus.elem;
                    if (m_have) begin
                        sb.push_back(mk(bus.elem, m_lo));
                        m_have = 1'b0;
                    end else if (bus.elem_last) begin
                        sb.push_back(mk(32'h0, bus.elem));
                    end else begin
                        m_lo   = bus.elem;
                        m_have = 1'b1;
                    end
                end
                if (bus.elem_last) begin
                    if (m_have) begin
                        sb.push_back(mk(32'h0, m_lo));
                        m_have = 1'b0;
                    end
                    sb.push_back(TERM_TUPLE);
                    m_runs++;
                    m_prev = '0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] k, input bit last);
        bit ok = 1'b0;
        bus.elem       = k;
        bus.elem_last  = last;
        bus.elem_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.elem_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("send_timeout", 64'(k), 64'(k) + 64'd1);
        @(posedge clk);
        #1;
        bus.elem_valid = 1'b0;
        bus.elem_last  = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        bus.read = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (bus.empty && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("drain_timeout", 64'(sb.size()), 64'd0);
        bus.read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.elem       = '0;
        bus.elem_valid = 1'b0;
        bus.elem_last  = 1'b0;
        bus.read       = 1'b0;

        #12;
        check_val("rst_empty", 64'(bus.empty), 64'd1);
        check_val("rst_tuple", bus.tuple, 64'd0);
        check_val("rst_run_count", 64'(bus.run_count), 64'd0);
        check_val("rst_err_zero", 64'(bus.err_zero), 64'd0);
        check_val("rst_underrun", 64'(bus.underrun), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_ready", 64'(bus.elem_ready), 64'd1);

        // Read pulse against an empty buffer.
        @(posedge clk);
        #1;
        bus.read = 1'b1;
        @(posedge clk);
        #1;
        bus.read = 1'b0;
        check_val("underrun_set", 64'(bus.underrun), 64'd1);
        check_val("underrun_empty", 64'(bus.empty), 64'd1);

        // Even run, then odd run.
        bus.read = 1'b1;
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd4, 1'b1);
        drain();
        check_val("run_count_1", 64'(bus.run_count), 64'd1);
        send(32'd5, 1'b0);
        send(32'd6, 1'b0);
        send(32'd7, 1'b1);
        drain();
        check_val("run_count_2", 64'(bus.run_count), 64'(m_runs));

        // Fill the buffer with reads held off; one read must release ready.
        for (int k = 20; k < 28; k++) send(32'(k), 1'b0);
        bus.elem       = 32'd28;
        bus.elem_valid = 1'b1;
        @(negedge clk);
        check_val("full_ready", 64'(bus.elem_ready), 64'd0);
        check_val("full_not_empty", 64'(bus.empty), 64'd0);
        @(negedge clk);
        check_val("full_ready_hold", 64'(bus.elem_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.read = 1'b1;
        @(posedge clk);
        #1;
        bus.read = 1'b0;
        @(negedge clk);
        check_val("release_ready", 64'(bus.elem_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.elem_valid = 1'b0;
        bus.read       = 1'b1;
        send(32'd29, 1'b1);
        drain();
        check_val("run_count_3", 64'(bus.run_count), 64'd3);

        // Zero keys: mid-run, closing a half tuple, and closing an empty run.
        check_val("err_zero_clear", 64'(bus.err_zero), 64'd0);
        bus.read = 1'b1;
        send(32'd30, 1'b0);
        send(32'd0, 1'b0);
        send(32'd31, 1'b1);
        send(32'd40, 1'b0);
        send(32'd0, 1'b1);
        send(32'd0, 1'b1);
        drain();
        check_val("err_zero_set", 64'(bus.err_zero), 64'(m_zero));
        check_val("run_count_6", 64'(bus.run_count), 64'd6);
        check_val("underrun_sticky", 64'(bus.underrun), 64'd1);

`ifdef RUN_FEEDER_ORDER_CHECK_EN
        check_val("err_order_clear", 64'(bus.err_order), 64'd0);
        send(32'd9, 1'b0);
        send(32'd3, 1'b1);
        drain();
        check_val("err_order_set", 64'(bus.err_order), 64'd1);
        send(32'd1, 1'b0);
        send(32'd2, 1'b1);
        drain();
        check_val("err_order_model", 64'(bus.err_order), 64'(m_order));
`endif

        // Reset in the middle of a run discards everything.
        bus.read = 1'b0;
        send(32'd50, 1'b0);
        send(32'd51, 1'b0);
        send(32'd52, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_empty", 64'(bus.empty), 64'd1);
        check_val("mid_rst_tuple", bus.tuple, 64'd0);
        check_val("mid_rst_run_count", 64'(bus.run_count), 64'd0);
        check_val("mid_rst_underrun", 64'(bus.underrun), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("mid_rst_ready", 64'(bus.elem_ready), 64'd1);
        bus.read = 1'b1;
        send(32'd60, 1'b0);
        send(32'd61, 1'b1);
        drain();
        check_val("post_rst_run_count", 64'(bus.run_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
